fifo_pkt_sched: RTL and testbench
=================================

# fifo_pkt_sched

Packet-level scheduler for the shared `fifo_sram` buffer. It sequences the buffer through three phases for each packet: receive from the upstream datapath, hand the buffer to the processor with `pc_en` set, then drain or flush to downstream. One packet is resident at a time. The block sits between the input queue, the `fifo_sram` instance and the RISC-V core's start/done handshake, and it exposes packet, drop and timeout counters as hardware registers.

## Interface
Parameters:
- `DATA_WIDTH`, 64, data word width.
- `CTRL_WIDTH`, `DATA_WIDTH/8`, ctrl width.
- `TIMEOUT`, 4096, maximum cycles allowed in PROC before a forced exit.
- `CNT_WIDTH`, 32, width of each statistics counter.

Ports:
- `clk`  in  1  single clock. All logic is on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  DATA_WIDTH  upstream data.
- `in_ctrl`  in  CTRL_WIDTH  upstream ctrl (0xFF = module header, 0 = body, other = last word).
- `in_wr`  in  1  upstream write strobe.
- `in_rdy`  out  1  upstream may write.
- `out_data`  out  DATA_WIDTH  downstream data.
- `out_ctrl`  out  CTRL_WIDTH  downstream ctrl.
- `out_wr`  out  1  downstream write strobe.
- `out_rdy`  in  1  downstream can accept.
- `fifo_din`  out  DATA_WIDTH+CTRL_WIDTH  `{in_ctrl,in_data}` to `fifo_sram.fifo_input`.
- `fifo_we`  out  1  to `wea`.
- `fifo_re`  out  1  to `reb`.
- `fifo_dout`  in  DATA_WIDTH+CTRL_WIDTH  from `fifo_output`.
- `fifo_almfull`  in  1  from `almfull`.
- `fifo_empty`  in  1  from `fifo_empty`.
- `fifo_stall`  in  1  from `stall`.
- `pc_en`  out  1  processor owns the SRAM.
- `proc_start`  out  1  one-cycle pulse to the core.
- `proc_done`  in  1  core finished; sampled only in PROC.
- `proc_drop`  in  1  qualifies `proc_done`: discard the packet.
- `pkt_cnt`, `drop_cnt`, `timeout_cnt`  out  CNT_WIDTH each  statistics.

## Operation
- States: RX, PROC, TX, FLUSH. Reset state is RX.
- RX:
  - `in_rdy = ~fifo_almfull & ~fifo_stall`.
  - `fifo_we = in_wr & in_rdy`. A write while `in_rdy` is low is ignored.
  - `body_seen` sets on an accepted word with ctrl 0.
  - An accepted word with ctrl ≠0 while `body_seen` is set is EOP. It goes to PROC, clears `body_seen` and loads `word_cnt` with the words written.
  - Header-only sequences never terminate a packet.
- PROC:
  - `pc_en = 1`, `in_rdy = 0`.
  - `proc_start` pulses in the first PROC cycle only.
  - `proc_done & ~proc_drop` → TX. `proc_done & proc_drop` → FLUSH.
  - Timeout counter reaches `TIMEOUT-1` without `proc_done` → TX and `timeout_cnt++`.
- TX:
  - `pc_en = 0`.
  - `fifo_re = out_rdy & ~fifo_empty & ~fifo_stall & (word_cnt != 0)`. Each read decrements `word_cnt`.
  - `out_wr` is `fifo_re` delayed one cycle.
  - `out_data`/`out_ctrl` come from `fifo_dout` in that cycle.
  - Exit to RX the cycle after the last `out_wr`, with `pkt_cnt++`.
- FLUSH: same read rule ignoring `out_rdy`, `out_wr` held 0. Exit as in TX, with `drop_cnt++`.
- Counters saturate at all-ones.
- Reset mid-operation: all state clears, no partial output is completed, and the buffer content is discarded by the `fifo_sram` reset.

## Timing
- Reset values: `in_rdy` 0 while `reset_n` low, then combinational per RX. `out_wr`, `fifo_we`, `fifo_re`, `pc_en`, `proc_start` 0. `out_data`/`out_ctrl` follow `fifo_dout`. All counters 0.
- Accept-to-buffer latency is 0 (`fifo_we` combinational). The EOP write cycle is the last RX cycle; `pc_en` rises the next cycle.
- Read latency is 1: `fifo_re` in cycle n → `out_wr` and valid data in n+1.
- `out_rdy` may drop at any time; reads stop in the same cycle and the word already in flight is still written.
- `proc_done` in the first PROC cycle is honoured, giving a minimum PROC dwell of 1 cycle.
- `proc_done` and timeout in the same cycle: done wins and `timeout_cnt` is unchanged.
- `fifo_stall` high pauses RX and TX with no state change.

## Structure
- The shared package `pkt_sched_pkg` holds:
  - the state enum;
  - ctrl codes `CTRL_HDR = 8'hFF` and `CTRL_BODY = 8'h00`;
  - the default `TIMEOUT`.
- One sub-module, `sat_counter`, parameterised by width with increment and clear, instantiated three times.
- The FSM and read pipeline live in the top level.

## Test plan
- Packet HDR(FF), 3 body words (00), EOP(0x08) with `proc_done` 5 cycles after `proc_start` → 5 `out_wr` identical in order, `pkt_cnt=1`, `pc_en` high exactly between EOP+1 and done.
- Same packet with `proc_drop=1` → no `out_wr`, `fifo_empty` at exit, `drop_cnt=1`, next packet accepted.
- No `proc_done`, `TIMEOUT=16` → exit to TX 16 cycles after entering PROC, `timeout_cnt=1`, packet forwarded.
- `out_rdy` toggling every cycle during TX → all words delivered once each, none duplicated.
- Upstream streams continuously into `fifo_almfull` → `in_rdy` low the same cycle and no word lost.
- Reset asserted in TX mid-packet → outputs zero immediately, state RX after release, counters 0.

Source files
------------

// File: rtl/pkt_sched_pkg.sv
// Shared definitions for the packet scheduler: FSM state encoding,
// upstream ctrl codes and default limits.
package pkt_sched_pkg;

  // Buffer ownership phases of one resident packet.
  typedef enum logic [1:0] {
    ST_RX    = 2'd0,
    ST_PROC  = 2'd1,
    ST_TX    = 2'd2,
    ST_FLUSH = 2'd3
  } pkt_state_e;

  // Upstream ctrl codes; any other non-zero value marks a last word.
  localparam logic [7:0] CTRL_HDR  = 8'hFF;
  localparam logic [7:0] CTRL_BODY = 8'h00;

  // Default processing budget in cycles.
  localparam int TIMEOUT_DEFAULT = 4096;

  // Width of the resident-packet word counter.
  localparam int WCNT_W = 16;

endpackage : pkt_sched_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones, clear has priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/fifo_pkt_sched.sv
// Packet scheduler: receives one packet into the shared buffer, hands the
// buffer to the processor, then drains it downstream or flushes it.
//
// Handshakes: upstream words transfer on a cycle with in_wr & in_rdy high
// (in_rdy is combinational from buffer status); a buffer read issued with
// fifo_re in cycle n presents its word on fifo_dout in cycle n+1, where
// out_wr is high for exactly that cycle; out_rdy only gates new reads.
module fifo_pkt_sched
  import pkt_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  // upstream
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [CTRL_WIDTH-1:0]          in_ctrl,
  input  logic                           in_wr,
  output logic                           in_rdy,
  // downstream
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_wr,
  input  logic                           out_rdy,
  // buffer
  output logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_din,
  output logic                           fifo_we,
  output logic                           fifo_re,
  input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_dout,
  input  logic                           fifo_almfull,
  input  logic                           fifo_empty,
  input  logic                           fifo_stall,
  // processor
  output logic                           pc_en,
  output logic                           proc_start,
  input  logic                           proc_done,
  input  logic                           proc_drop,
  // statistics
  output logic [CNT_WIDTH-1:0]           pkt_cnt,
  output logic [CNT_WIDTH-1:0]           drop_cnt,
  output logic [CNT_WIDTH-1:0]           timeout_cnt,
  // observability
  output pkt_state_e                     state_dbg
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CTRL_WIDTH-1:0] BODY_CODE = CTRL_WIDTH'(CTRL_BODY);

  pkt_state_e        state_q, state_d;
  logic              body_seen_q;
  logic [WCNT_W-1:0] word_cnt_q;
  logic [TW-1:0]     timer_q;
  logic              out_wr_q;

  logic eop;
  logic rd_ok;
  logic pkt_inc, drop_inc, to_inc;

  // Buffer write port carries ctrl above data; read data passes straight out.
  assign fifo_din  = {in_ctrl, in_data};
  assign out_data  = fifo_dout[DATA_WIDTH-1:0];
  assign out_ctrl  = fifo_dout[DATA_WIDTH+CTRL_WIDTH-1:DATA_WIDTH];
  assign out_wr    = out_wr_q;
  assign state_dbg = state_q;

  // A read may be issued when the buffer holds data for this packet.
  assign rd_ok = ~fifo_empty & ~fifo_stall & (word_cnt_q != '0);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RX;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d    = state_q;
    in_rdy     = 1'b0;
    fifo_we    = 1'b0;
    fifo_re    = 1'b0;
    pc_en      = 1'b0;
    proc_start = 1'b0;
    eop        = 1'b0;
    pkt_inc    = 1'b0;
    drop_inc   = 1'b0;
    to_inc     = 1'b0;
    unique case (state_q)
      ST_RX: begin
        // reset_n term keeps in_rdy low for the whole reset interval
        in_rdy  = reset_n & ~fifo_almfull & ~fifo_stall;
        fifo_we = in_wr & in_rdy;
        // a non-body word ends the packet only once a body word was seen,
        // so header-only runs keep accumulating
        if (fifo_we && body_seen_q && (in_ctrl != BODY_CODE)) begin
          eop     = 1'b1;
          state_d = ST_PROC;
        end
      end
      ST_PROC: begin
        pc_en      = 1'b1;
        proc_start = (timer_q == '0);
        // done is checked before the timeout so a coincident done wins
        if (proc_done) begin
          state_d = proc_drop ? ST_FLUSH : ST_TX;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_TX;
          to_inc  = 1'b1;
        end
      end
      ST_TX: begin
        fifo_re = out_rdy & rd_ok;
        // word_cnt hits zero in the cycle the last word is on out_wr
        if (word_cnt_q == '0) begin
          state_d = ST_RX;
          pkt_inc = 1'b1;
        end
      end
      ST_FLUSH: begin
        fifo_re = rd_ok;
        if (word_cnt_q == '0) begin
          state_d  = ST_RX;
          drop_inc = 1'b1;
        end
      end
      default: state_d = ST_RX;
    endcase
  end

  // Body tracking and resident word count: up on writes, down on reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      body_seen_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      if (eop) begin
        body_seen_q <= 1'b0;
      end else if (fifo_we && (in_ctrl == BODY_CODE)) begin
        body_seen_q <= 1'b1;
      end
      if (fifo_we) begin
        word_cnt_q <= word_cnt_q + WCNT_W'(1);
      end else if (fifo_re) begin
        word_cnt_q <= word_cnt_q - WCNT_W'(1);
      end
    end
  end

  // Cycles spent in PROC; zero marks the first PROC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (state_q == ST_PROC) begin
      timer_q <= timer_q + TW'(1);
    end else begin
      timer_q <= '0;
    end
  end

  // Read pipeline: a TX read becomes a downstream write one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_wr_q <= 1'b0;
    end else begin
      out_wr_q <= fifo_re & (state_q == ST_TX);
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_pkt_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (pkt_inc),
    .cnt     (pkt_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (drop_inc),
    .cnt     (drop_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_timeout_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (to_inc),
    .cnt     (timeout_cnt)
  );

endmodule : fifo_pkt_sched

// File: tb/tb_fifo_pkt_sched.sv
// Directed bench for fifo_pkt_sched with a behavioural buffer model,
// an expected-word queue and a monitor on the downstream port.
module tb_fifo_pkt_sched;
  import pkt_sched_pkg::*;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [DW-1:0]    in_data = '0;
  logic [CW-1:0]    in_ctrl = '0;
  logic             in_wr = 1'b0;
  logic             in_rdy;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy = 1'b1;
  logic [DW+CW-1:0] fifo_din;
  logic             fifo_we;
  logic             fifo_re;
  logic [DW+CW-1:0] fifo_dout;
  logic             fifo_almfull;
  logic             fifo_empty;
  logic             fifo_stall = 1'b0;
  logic             pc_en;
  logic             proc_start;
  logic             proc_done = 1'b0;
  logic             proc_drop = 1'b0;
  logic [31:0]      pkt_cnt;
  logic [31:0]      drop_cnt;
  logic [31:0]      timeout_cnt;
  pkt_state_e       state_dbg;

  fifo_pkt_sched #(
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .TIMEOUT    (TO),
    .CNT_WIDTH  (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_wr        (in_wr),
    .in_rdy       (in_rdy),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_rdy      (out_rdy),
    .fifo_din     (fifo_din),
    .fifo_we      (fifo_we),
    .fifo_re      (fifo_re),
    .fifo_dout    (fifo_dout),
    .fifo_almfull (fifo_almfull),
    .fifo_empty   (fifo_empty),
    .fifo_stall   (fifo_stall),
    .pc_en        (pc_en),
    .proc_start   (proc_start),
    .proc_done    (proc_done),
    .proc_drop    (proc_drop),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt),
    .timeout_cnt  (timeout_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- buffer model ----------------
  logic [DW+CW-1:0] mem_q[$];
  logic             alm_force = 1'b0;
  logic             alm_lvl;
  assign fifo_almfull = alm_force | alm_lvl;

  always @(posedge clk or negedge reset_n) begin
    int n;
    if (!reset_n) begin
      mem_q.delete();
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
      alm_lvl    <= 1'b0;
    end else begin
      n = mem_q.size();
      if (fifo_re && n > 0) begin
        fifo_dout <= mem_q.pop_front();
        n--;
      end
      if (fifo_we) begin
        mem_q.push_back(fifo_din);
        n++;
      end
      fifo_empty <= (n == 0);
      alm_lvl    <= (n >= 30);
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW+CW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DW+CW-1:0] got,
                       input logic [DW+CW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every downstream write must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_n && out_wr) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_word: got=%0h required=none at %0t", {out_ctrl, out_data}, $time);
      end else begin
        check("out_word", {out_ctrl, out_data}, exp_q.pop_front());
      end
    end
  end

  // out_rdy toggler for back-pressure tests.
  logic tog_en = 1'b0;
  always @(posedge clk) begin
    if (tog_en) begin
      #1;
      out_rdy = ~out_rdy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [DW-1:0] d, input logic [CW-1:0] c);
    int w = 0;
    in_data = d;
    in_ctrl = c;
    in_wr   = 1'b1;
    @(negedge clk);
    while (!in_rdy && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_rdy) check("in_rdy_wait", {71'd0, in_rdy}, 72'd1);
    @(posedge clk);
    #1;
    in_wr = 1'b0;
  endtask

  // n_hdr header words, n_body body words, then the last word.
  task automatic send_pkt(input int n_hdr, input int n_body, input logic [CW-1:0] eop_c,
                          input logic fwd, input logic [DW-1:0] base);
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    for (int i = 0; i < n_hdr + n_body + 1; i++) begin
      if (i < n_hdr) c = CTRL_HDR;
      else if (i < n_hdr + n_body) c = CTRL_BODY;
      else c = eop_c;
      d = base + DW'(i);
      if (fwd) exp_q.push_back({c, d});
      send_word(d, c);
    end
  endtask

  // Answer the first proc_start after dly cycles.
  task automatic proc_respond(input int dly, input logic drop);
    int w = 0;
    @(negedge clk);
    while (!proc_start && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("proc_start_seen", {71'd0, proc_start}, 72'd1);
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    proc_done = 1'b1;
    proc_drop = drop;
    @(posedge clk);
    #1;
    proc_done = 1'b0;
    proc_drop = 1'b0;
  endtask

  // Consecutive cycles with pc_en high, starting at the next cycle.
  task automatic count_pc(output int n);
    n = 0;
    @(negedge clk);
    while (pc_en && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rx(input string name);
    int w = 0;
    @(negedge clk);
    while (state_dbg != ST_RX && w < 500) begin
      w++;
      @(negedge clk);
    end
    check(name, {70'd0, state_dbg}, {70'd0, ST_RX});
    check({name, "_drained"}, 72'(exp_q.size()), 72'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence ----------------
  initial begin
    int n;

    // reset state
    #12;
    @(negedge clk);
    check("rst_in_rdy", {71'd0, in_rdy}, 72'd0);
    check("rst_out_wr", {71'd0, out_wr}, 72'd0);
    check("rst_pc_en", {71'd0, pc_en}, 72'd0);
    check("rst_cnts", {8'd0, pkt_cnt | drop_cnt | timeout_cnt}, 72'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_in_rdy", {71'd0, in_rdy}, 72'd1);
    check("idle_state", {70'd0, state_dbg}, {70'd0, ST_RX});

    // stall blocks upstream in RX
    fifo_stall = 1'b1;
    @(negedge clk);
    check("stall_in_rdy", {71'd0, in_rdy}, 72'd0);
    @(posedge clk);
    #1;
    fifo_stall = 1'b0;

    // 1: basic forward, done 5 cycles after start
    send_pkt(1, 3, 8'h08, 1'b1, 64'h1000);
    fork
      proc_respond(5, 1'b0);
      count_pc(n);
    join
    check("t1_pc_en_cycles", 72'(n), 72'd6);
    wait_rx("t1_rx");
    check("t1_pkt_cnt", 72'(pkt_cnt), 72'd1);

    // 2: dropped packet
    send_pkt(1, 3, 8'h08, 1'b0, 64'h2000);
    proc_respond(2, 1'b1);
    wait_rx("t2_rx");
    check("t2_fifo_empty", {71'd0, fifo_empty}, 72'd1);
    check("t2_drop_cnt", 72'(drop_cnt), 72'd1);
    check("t2_pkt_cnt", 72'(pkt_cnt), 72'd1);

    // 3: timeout forwards the packet, with repeated header words first
    send_pkt(2, 2, 8'h03, 1'b1, 64'h3000);
    count_pc(n);
    check("t3_pc_en_cycles", 72'(n), 72'(TO));
    check("t3_timeout_cnt", 72'(timeout_cnt), 72'd1);
    wait_rx("t3_rx");
    check("t3_pkt_cnt", 72'(pkt_cnt), 72'd2);

    // 4: done in the first PROC cycle
    send_pkt(1, 1, 8'h01, 1'b1, 64'h4000);
    fork
      proc_respond(0, 1'b0);
      count_pc(n);
    join
    check("t4_pc_en_cycles", 72'(n), 72'd1);
    wait_rx("t4_rx");

    // 5: done coincides with the timeout cycle
    send_pkt(1, 2, 8'h08, 1'b1, 64'h5000);
    fork
      proc_respond(TO - 1, 1'b0);
      count_pc(n);
    join
    check("t5_pc_en_cycles", 72'(n), 72'(TO));
    check("t5_timeout_cnt", 72'(timeout_cnt), 72'd1);
    wait_rx("t5_rx");
    check("t5_pkt_cnt", 72'(pkt_cnt), 72'd4);

    // 6: out_rdy toggling plus a short stall during TX
    send_pkt(1, 5, 8'h08, 1'b1, 64'h6000);
    tog_en = 1'b1;
    proc_respond(3, 1'b0);
    fork
      wait_rx("t6_rx");
      begin
        repeat (3) @(posedge clk);
        #1;
        fifo_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fifo_stall = 1'b0;
      end
    join
    tog_en = 1'b0;
    #2;
    out_rdy = 1'b1;
    check("t6_pkt_cnt", 72'(pkt_cnt), 72'd5);

    // 7: almost-full asserted while upstream streams
    fork
      send_pkt(1, 6, 8'h08, 1'b1, 64'h7000);
      begin
        repeat (3) @(posedge clk);
        #1;
        alm_force = 1'b1;
        @(negedge clk);
        check("t7_almfull_in_rdy", {71'd0, in_rdy}, 72'd0);
        repeat (2) @(posedge clk);
        #1;
        alm_force = 1'b0;
      end
    join
    proc_respond(1, 1'b0);
    wait_rx("t7_rx");
    check("t7_pkt_cnt", 72'(pkt_cnt), 72'd6);

    // 8: reset in the middle of TX
    send_pkt(1, 6, 8'h08, 1'b1, 64'h8000);
    proc_respond(0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_wr && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("t8_tx_started", {71'd0, out_wr}, 72'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("t8_rst_out_wr", {71'd0, out_wr}, 72'd0);
    check("t8_rst_fifo_re", {71'd0, fifo_re}, 72'd0);
    check("t8_rst_in_rdy", {71'd0, in_rdy}, 72'd0);
    check("t8_rst_cnts", {8'd0, pkt_cnt | drop_cnt | timeout_cnt}, 72'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("t8_state", {70'd0, state_dbg}, {70'd0, ST_RX});
    check("t8_in_rdy", {71'd0, in_rdy}, 72'd1);
    check("t8_pkt_cnt", 72'(pkt_cnt), 72'd0);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    total++;
    bad++;
    $display("FAIL watchdog: got=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fifo_pkt_sched
